// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// Shared definitions for the UART RX FIFO controller.
//   - register addresses on the 2-bit register bus
//   - STATUS / CTRL / IRQ_CLR bit positions
//   - bus FSM state enumeration
package uart_rx_fifo_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_IRQ_CLR = 2'd3;

    // STATUS fields
    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_TMO     = 3;
    localparam int unsigned STAT_CNT_LSB = 8;

    // CTRL fields
    localparam int unsigned CTRL_THR_LSB = 0;
    localparam int unsigned CTRL_THR_W   = 8;
    localparam int unsigned CTRL_THR_IE  = 8;
    localparam int unsigned CTRL_TMO_IE  = 9;
    localparam int unsigned CTRL_OVF_IE  = 10;
    localparam int unsigned CTRL_TMO_LSB = 16;
    localparam int unsigned CTRL_TMO_W   = 16;

    // IRQ_CLR write bits
    localparam int unsigned CLR_OVF = 2;
    localparam int unsigned CLR_TMO = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_ACK  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_timeout_cnt.sv
// Character-timeout counter for the RX FIFO.
// Counts idle cycles while the FIFO holds data; any received byte, any pop,
// or an empty FIFO restarts the count. Sets a sticky flag when the count
// equals a nonzero timeout value.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   rx_valid_i         received-byte strobe (restarts count)
//   pop_i              FIFO read enable (restarts count)
//   fifo_empty_i       FIFO empty flag (holds count at zero)
//   tmo_cycles_i       timeout value, 0 disables
//   clr_i              sticky clear request (a same-cycle set wins)
//   timeout_o          timeout sticky
module uart_rx_timeout_cnt
    import uart_rx_fifo_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_valid_i,
    input  logic                  pop_i,
    input  logic                  fifo_empty_i,
    input  logic [CTRL_TMO_W-1:0] tmo_cycles_i,
    input  logic                  clr_i,
    output logic                  timeout_o
);

    logic [CTRL_TMO_W-1:0] cnt_q, cnt_d;
    logic                  sticky_q, sticky_d;
    logic                  hit;

    always_comb begin
        cnt_d = cnt_q;
        if (rx_valid_i || pop_i || fifo_empty_i)
            cnt_d = '0;
        else if (cnt_q != {CTRL_TMO_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    assign hit      = (tmo_cycles_i != '0) && (cnt_q == tmo_cycles_i);
    assign sticky_d = hit | (sticky_q & ~clr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign timeout_o = sticky_q;

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side FIFO controller for the UART user block.
// Pushes received bytes into an external synchronous FIFO, serves register
// bus accesses (DATA pop, STATUS, CTRL, IRQ_CLR), tracks overflow and
// character timeout, and drives a registered, maskable interrupt.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   rx_valid_i, rx_data_i     received byte strobe / data
//   fifo_w_en_o, fifo_din_o   FIFO push
//   fifo_r_en_o, fifo_dout_i  FIFO pop; dout valid the cycle after r_en
//   fifo_full_i, fifo_empty_i, fifo_count_i   FIFO flags / occupancy
//   bus_req_i .. bus_wdata_i  register bus request (held until ack)
//   bus_rdata_o, bus_ack_o    registered read data, one-cycle ack
//   irq_o                     level interrupt
module uart_rx_fifo_ctrl
    import uart_rx_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BUS_W      = 32,
    parameter int COUNT_W    = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_valid_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    output logic                  fifo_w_en_o,
    output logic [DATA_WIDTH-1:0] fifo_din_o,
    output logic                  fifo_r_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    input  logic                  fifo_full_i,
    input  logic                  fifo_empty_i,
    input  logic [COUNT_W-1:0]    fifo_count_i,
    input  logic                  bus_req_i,
    input  logic                  bus_we_i,
    input  logic [1:0]            bus_addr_i,
    input  logic [BUS_W-1:0]      bus_wdata_i,
    output logic [BUS_W-1:0]      bus_rdata_o,
    output logic                  bus_ack_o,
    output logic                  irq_o
);

    rx_state_e state_q, state_d;

    logic [CTRL_THR_W-1:0] thr_q;
    logic                  thr_ie_q, tmo_ie_q, ovf_ie_q;
    logic [CTRL_TMO_W-1:0] tmo_cyc_q;
    logic [BUS_W-1:0]      rdata_q, rdata_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_q, irq_d;
    logic                  timeout;

    logic                  accept, is_pop, ctrl_wr, clr_wr;
    logic [BUS_W-1:0]      status_w, ctrl_w;
    logic [7:0]            cnt8;
    logic                  unused_wdata;

    // ------------------------------------------------------------ push path
    assign fifo_din_o  = rx_data_i;
    assign fifo_w_en_o = rx_valid_i & ~fifo_full_i;

    // ------------------------------------------------------------ bus decode
    assign accept  = (state_q == ST_IDLE) && bus_req_i;
    // Only a DATA read with something in the FIFO takes the long pop path.
    assign is_pop  = accept && !bus_we_i && (bus_addr_i == ADDR_DATA) && !fifo_empty_i;
    assign ctrl_wr = accept && bus_we_i && (bus_addr_i == ADDR_CTRL);
    assign clr_wr  = accept && bus_we_i && (bus_addr_i == ADDR_IRQ_CLR);

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_pop ? ST_POP : ST_ACK;
            ST_POP:  state_d = ST_CAPT;
            ST_CAPT: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // r_en is masked by reset so an abandoned pop never removes a byte.
    always_comb begin
        fifo_r_en_o = 1'b0;
        bus_ack_o   = 1'b0;
        case (state_q)
            ST_POP:  fifo_r_en_o = ~rst_i;
            ST_ACK:  bus_ack_o   = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------ registers view
    always_comb begin
        status_w                               = '0;
        status_w[STAT_EMPTY]                   = fifo_empty_i;
        status_w[STAT_FULL]                    = fifo_full_i;
        status_w[STAT_OVF]                     = ovf_q;
        status_w[STAT_TMO]                     = timeout;
        status_w[STAT_CNT_LSB +: COUNT_W]      = fifo_count_i;
    end

    always_comb begin
        ctrl_w                                 = '0;
        ctrl_w[CTRL_THR_LSB +: CTRL_THR_W]     = thr_q;
        ctrl_w[CTRL_THR_IE]                    = thr_ie_q;
        ctrl_w[CTRL_TMO_IE]                    = tmo_ie_q;
        ctrl_w[CTRL_OVF_IE]                    = ovf_ie_q;
        ctrl_w[CTRL_TMO_LSB +: CTRL_TMO_W]     = tmo_cyc_q;
    end

    // Read data: captured from the FIFO in CAPT, otherwise loaded on accept.
    // Writes and empty DATA reads return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (state_q == ST_CAPT) begin
            rdata_d = {{(BUS_W-DATA_WIDTH){1'b0}}, fifo_dout_i};
        end else if (accept && !is_pop) begin
            rdata_d = '0;
            if (!bus_we_i) begin
                case (bus_addr_i)
                    ADDR_STATUS: rdata_d = status_w;
                    ADDR_CTRL:   rdata_d = ctrl_w;
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ stickies / irq
    assign ovf_d = (rx_valid_i & fifo_full_i) | (ovf_q & ~(clr_wr & bus_wdata_i[CLR_OVF]));

    always_comb begin
        cnt8                 = '0;
        cnt8[COUNT_W-1:0]    = fifo_count_i;
    end

    assign irq_d = (thr_ie_q & (cnt8 >= thr_q) & ~fifo_empty_i)
                 | (tmo_ie_q & timeout)
                 | (ovf_ie_q & ovf_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q   <= '0;
            thr_q     <= '0;
            thr_ie_q  <= 1'b0;
            tmo_ie_q  <= 1'b0;
            ovf_ie_q  <= 1'b0;
            tmo_cyc_q <= '0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
            if (ctrl_wr) begin
                thr_q     <= bus_wdata_i[CTRL_THR_LSB +: CTRL_THR_W];
                thr_ie_q  <= bus_wdata_i[CTRL_THR_IE];
                tmo_ie_q  <= bus_wdata_i[CTRL_TMO_IE];
                ovf_ie_q  <= bus_wdata_i[CTRL_OVF_IE];
                tmo_cyc_q <= bus_wdata_i[CTRL_TMO_LSB +: CTRL_TMO_W];
            end
        end
    end

    assign bus_rdata_o = rdata_q;
    assign irq_o       = irq_q;

    // CTRL bits [15:11] are reserved.
    assign unused_wdata = ^bus_wdata_i[CTRL_TMO_LSB-1:CTRL_OVF_IE+1];

    // ------------------------------------------------------------ timeout
    uart_rx_timeout_cnt u_tmo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_valid_i   (rx_valid_i),
        .pop_i        (fifo_r_en_o),
        .fifo_empty_i (fifo_empty_i),
        .tmo_cycles_i (tmo_cyc_q),
        .clr_i        (clr_wr & bus_wdata_i[CLR_TMO]),
        .timeout_o    (timeout)
    );

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl with a behavioural 4-slot FIFO
// (3 usable entries) attached.
module tb_uart_rx_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        fifo_w_en, fifo_r_en;
    logic [7:0]  fifo_din, fifo_dout;
    logic        fifo_full, fifo_empty;
    logic [1:0]  fifo_count;
    logic        bus_req, bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack, irq;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_ctrl #(.DEPTH(4), .DATA_WIDTH(8), .BUS_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .fifo_w_en_o  (fifo_w_en),
        .fifo_din_o   (fifo_din),
        .fifo_r_en_o  (fifo_r_en),
        .fifo_dout_i  (fifo_dout),
        .fifo_full_i  (fifo_full),
        .fifo_empty_i (fifo_empty),
        .fifo_count_i (fifo_count),
        .bus_req_i    (bus_req),
        .bus_we_i     (bus_we),
        .bus_addr_i   (bus_addr),
        .bus_wdata_i  (bus_wdata),
        .bus_rdata_o  (bus_rdata),
        .bus_ack_o    (bus_ack),
        .irq_o        (irq)
    );

    // Behavioural FIFO: registered dout, flags from registered occupancy.
    logic [7:0] fq[$];
    logic [2:0] fcnt = 3'd0;
    logic [7:0] fdout = 8'h00;
    assign fifo_dout  = fdout;
    assign fifo_full  = (fcnt == 3'd3);
    assign fifo_empty = (fcnt == 3'd0);
    assign fifo_count = fcnt[1:0];

    always @(posedge clk) begin
        logic [2:0] n;
        n = fcnt;
        if (fifo_r_en && fq.size() > 0) begin
            fdout <= fq.pop_front();
            n = n - 3'd1;
        end
        if (fifo_w_en && fq.size() < 3) begin
            fq.push_back(fifo_din);
            n = n + 3'd1;
        end
        fcnt <= n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // One bus transaction; lat = edges from request to the ack cycle,
    // ren = cycles with fifo_r_en high during the transaction.
    task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                            input bit with_push, output logic [31:0] rd,
                            output int lat, output int ren);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        if (with_push) begin
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
        end
        lat = 0;
        ren = 0;
        while (!bus_ack && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            rx_valid = 1'b0;
            if (fifo_r_en) ren++;
        end
        if (!bus_ack) chk("ack_timeout", 32'd0, 32'd1);
        rd        = bus_rdata;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
        cyc(1);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp,
                          input int exp_lat, input int exp_ren);
        logic [31:0] rd;
        int lat, ren;
        bus_xfer(1'b0, addr, 32'd0, 1'b0, rd, lat, ren);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_ren"}, ren, exp_ren);
    endtask

    task automatic wr(input string tag, input logic [1:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        int lat, ren;
        bus_xfer(1'b1, addr, wd, 1'b0, rd, lat, ren);
        chk({tag, "_lat"}, lat, 1);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, ren;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        cyc(2);
        chk("rst_ack", bus_ack, 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_ren", fifo_r_en, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b0;
        cyc(1);
        rd_chk("rst_status", 2'd1, 32'h1, 1, 0);
        rd_chk("rst_ctrl", 2'd2, 32'h0, 1, 0);

        // CTRL reserved bits read zero
        wr("ctrl_all", 2'd2, 32'hFFFF_FFFF);
        rd_chk("ctrl_mask", 2'd2, 32'hFFFF_07FF, 1, 0);
        wr("ctrl_zero", 2'd2, 32'h0);

        // basic push / pop
        push(8'h41);
        push(8'h42);
        rd_chk("pop1", 2'd0, 32'h41, 3, 1);
        rd_chk("pop2", 2'd0, 32'h42, 3, 1);

        // overflow: 4th byte dropped
        wr("ctrl_ovf", 2'd2, 32'h400);
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        rd_chk("ovf_status", 2'd1, 32'h306, 1, 0);
        chk("ovf_irq", irq, 1);
        rd_chk("ovf_pop1", 2'd0, 32'h10, 3, 1);
        rd_chk("ovf_pop2", 2'd0, 32'h11, 3, 1);
        rd_chk("ovf_pop3", 2'd0, 32'h12, 3, 1);
        wr("ovf_clr", 2'd3, 32'h4);
        rd_chk("ovf_clr_status", 2'd1, 32'h1, 1, 0);
        chk("ovf_irq_low", irq, 0);

        // threshold
        wr("ctrl_thr", 2'd2, 32'h102);
        push(8'h21);
        cyc(2);
        chk("thr_irq_1byte", irq, 0);
        push(8'h22);
        chk("thr_irq_pre", irq, 0);
        cyc(1);
        chk("thr_irq_2byte", irq, 1);
        rd_chk("thr_pop", 2'd0, 32'h21, 3, 1);
        chk("thr_irq_fall", irq, 0);
        rd_chk("thr_drain", 2'd0, 32'h22, 3, 1);

        // character timeout = 10 cycles
        wr("ctrl_tmo", 2'd2, 32'h000A_0200);
        push(8'h31);
        cyc(10);
        chk("tmo_irq_early", irq, 0);
        cyc(3);
        chk("tmo_irq_set", irq, 1);
        rd_chk("tmo_status", 2'd1, 32'h108, 1, 0);
        wr("tmo_clr", 2'd3, 32'h8);
        rd_chk("tmo_clr_status", 2'd1, 32'h100, 1, 0);
        chk("tmo_irq_clr", irq, 0);
        rd_chk("tmo_drain", 2'd0, 32'h31, 3, 1);
        wr("ctrl_off", 2'd2, 32'h0);

        // empty read, ignored write
        rd_chk("empty_rd", 2'd0, 32'h0, 1, 0);
        wr("data_wr", 2'd0, 32'hAB);
        rd_chk("data_wr_status", 2'd1, 32'h1, 1, 0);

        // overflow set coincident with clear: set wins
        push(8'h51); push(8'h52); push(8'h53);
        bus_xfer(1'b1, 2'd3, 32'h4, 1'b1, rd, lat, ren);
        chk("coin_lat", lat, 1);
        rd_chk("coin_status", 2'd1, 32'h306, 1, 0);
        rd_chk("irqclr_rd", 2'd3, 32'h0, 1, 0);

        // reset while in POP
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
        cyc(1);
        chk("rpop_ren", fifo_r_en, 1);
        rst = 1'b1;
        bus_req = 1'b0;
        #1;
        chk("rpop_ren_gated", fifo_r_en, 0);
        cyc(1);
        chk("rpop_ack", bus_ack, 0);
        chk("rpop_rdata", bus_rdata, 0);
        chk("rpop_irq", irq, 0);
        chk("rpop_ren_rst", fifo_r_en, 0);
        rst = 1'b0;
        cyc(1);
        chk("rpop_ack_after", bus_ack, 0);
        rd_chk("rpop_pop", 2'd0, 32'h51, 3, 1);
        rd_chk("rpop_status", 2'd1, 32'h200, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
